// File: rtl/alu_rf_pkg.sv
// Shared definitions for the register-file/ALU sequencer: op codes and controller state encoding.
package alu_rf_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_GT   = 4'd7;
  localparam logic [3:0] OP_LT   = 4'd8;
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    RESP
  } state_e;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_rf_sequencer.sv
// Multi-cycle controller for the shared RF + ALU datapath: accept, execute, write back, respond.
module alu_rf_sequencer
  import alu_rf_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter bit          PROTECT_R0 = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [4:0]        req_shamt,
  input  logic              req_wsrc,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] rf_rr1,
  output logic [ADDR_W-1:0] rf_rr2,
  output logic [ADDR_W-1:0] rf_wr,
  output logic              rf_we,
  output logic              wd_sel,
  output logic [DATA_W-1:0] ext_wd,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [4:0]        shamt_q;
  logic              wsrc_q, wen_q, err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              write_ok;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      shamt_q  <= '0;
      wsrc_q   <= 1'b0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        op_q    <= req_op;
        rs_q    <= req_rs;
        rt_q    <= req_rt;
        rd_q    <= req_rd;
        shamt_q <= req_shamt;
        wsrc_q  <= req_wsrc;
        wen_q   <= req_wen;
        err_q   <= op_illegal(req_op);
        wdata_q <= req_wdata;
      end
      // Illegal ops report a zeroed result rather than whatever the ALU produced.
      if (state_q == EXEC) begin
        result_q <= err_q ? '0 : alu_result;
        zero_q   <= err_q ? 1'b0 : alu_zero;
      end
    end
  end

  assign write_ok = wen_q && !err_q && !(PROTECT_R0 && (rd_q == '0));

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rf_rr1    = '0;
    rf_rr2    = '0;
    rf_wr     = '0;
    rf_we     = 1'b0;
    wd_sel    = 1'b0;
    ext_wd    = '0;
    alu_op    = '0;
    alu_shamt = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = EXEC;
      end
      EXEC: begin
        rf_rr1    = rs_q;
        rf_rr2    = rt_q;
        alu_op    = op_q;
        alu_shamt = shamt_q;
        state_d   = WB;
      end
      WB: begin
        // Keep the read side steady so the ALU-path write data does not move during the write.
        rf_rr1    = rs_q;
        rf_rr2    = rt_q;
        alu_op    = op_q;
        alu_shamt = shamt_q;
        rf_wr     = rd_q;
        rf_we     = write_ok;
        wd_sel    = ~wsrc_q;
        ext_wd    = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench: sequencer plus behavioural RF/ALU/write-mux, scoreboard of expected responses and writes.
module tb_alu_rf_sequencer;
  import alu_rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_op = '0;
  logic [AW-1:0] req_rs = '0, req_rt = '0, req_rd = '0;
  logic [4:0]    req_shamt = '0;
  logic          req_wsrc = 1'b0, req_wen = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;

  // Main instance (R0 writable)
  logic          req_ready, rf_we, wd_sel, alu_zero, rsp_valid, rsp_zero, rsp_err, busy;
  logic [AW-1:0] rf_rr1, rf_rr2, rf_wr;
  logic [DW-1:0] ext_wd, alu_result, rsp_result, wd;
  logic [3:0]    alu_op;
  logic [4:0]    alu_shamt;

  // Protected instance (R0 write-suppressed), driven in lockstep
  logic          p_req_ready, p_rf_we, p_wd_sel, p_alu_zero, p_rsp_valid, p_rsp_zero, p_rsp_err;
  logic          p_busy;
  logic [AW-1:0] p_rf_rr1, p_rf_rr2, p_rf_wr;
  logic [DW-1:0] p_ext_wd, p_alu_result, p_rsp_result, p_wd;
  logic [3:0]    p_alu_op;
  logic [4:0]    p_alu_shamt;

  logic [DW-1:0] rf     [32] = '{default: '0};
  logic [DW-1:0] rf_p   [32] = '{default: '0};
  logic [DW-1:0] exp_rf [32] = '{default: '0};

  int we_cnt = 0;
  int p_we_cnt = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
    logic          we;
    logic          p_we;
    logic [AW-1:0] rd;
  } exp_t;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [4:0] sh);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return $signed(a) >>> sh;
      4'd7:    return {31'b0, $signed(a) > $signed(b)};
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  assign alu_result   = alu_fn(alu_op, rf[rf_rr1], rf[rf_rr2], alu_shamt);
  assign alu_zero     = (rf[rf_rr1] - rf[rf_rr2]) == '0;
  assign wd           = wd_sel ? alu_result : ext_wd;
  assign p_alu_result = alu_fn(p_alu_op, rf_p[p_rf_rr1], rf_p[p_rf_rr2], p_alu_shamt);
  assign p_alu_zero   = (rf_p[p_rf_rr1] - rf_p[p_rf_rr2]) == '0;
  assign p_wd         = p_wd_sel ? p_alu_result : p_ext_wd;

  always @(posedge Clk) begin
    if (rf_we) begin
      rf[rf_wr] <= wd;
      we_cnt    <= we_cnt + 1;
    end
    if (p_rf_we) begin
      rf_p[p_rf_wr] <= p_wd;
      p_we_cnt      <= p_we_cnt + 1;
    end
  end

  alu_rf_sequencer #(.DATA_W(DW), .ADDR_W(AW), .PROTECT_R0(1'b0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_wsrc(req_wsrc), .req_wen(req_wen), .req_wdata(req_wdata),
    .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_wr(rf_wr), .rf_we(rf_we), .wd_sel(wd_sel),
    .ext_wd(ext_wd), .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_result(alu_result),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  alu_rf_sequencer #(.DATA_W(DW), .ADDR_W(AW), .PROTECT_R0(1'b1)) dut_p (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_ready(p_req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_wsrc(req_wsrc), .req_wen(req_wen), .req_wdata(req_wdata),
    .rf_rr1(p_rf_rr1), .rf_rr2(p_rf_rr2), .rf_wr(p_rf_wr), .rf_we(p_rf_we), .wd_sel(p_wd_sel),
    .ext_wd(p_ext_wd), .alu_op(p_alu_op), .alu_shamt(p_alu_shamt), .alu_result(p_alu_result),
    .alu_zero(p_alu_zero), .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(p_rsp_result), .rsp_zero(p_rsp_zero), .rsp_err(p_rsp_err), .busy(p_busy)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for its response (optionally holding rsp_ready low) and score it.
  task automatic do_op(input logic [3:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic [4:0] sh, input logic wsrc,
                       input logic wen, input logic [DW-1:0] wdata, input int hold);
    exp_t e, got;
    logic [DW-1:0] a, b;
    int n, base, pbase;
    a      = exp_rf[rs];
    b      = exp_rf[rt];
    e.err  = (op > OP_LAST);
    e.res  = e.err ? '0 : alu_fn(op, a, b, sh);
    e.zero = e.err ? 1'b0 : (a == b);
    e.we   = wen && !e.err;
    e.p_we = e.we && (rd != '0);
    e.rd   = rd;
    if (e.we) exp_rf[rd] = wsrc ? wdata : e.res;
    sb.push_back(e);

    @(negedge Clk);
    base      = we_cnt;
    pbase     = p_we_cnt;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_shamt = sh;
    req_wsrc  = wsrc;
    req_wen   = wen;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) check_eq("accept_timeout", 0, 1);
    @(posedge Clk);
    @(negedge Clk);
    req_valid = 1'b0;
    check_eq("req_ready_busy", {31'b0, req_ready}, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) check_eq("rsp_timeout", 0, 1);
    got = sb.pop_front();
    check_eq("rsp_result", rsp_result, got.res);
    check_eq("rsp_zero", {31'b0, rsp_zero}, {31'b0, got.zero});
    check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, got.err});
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk);
        check_eq("hold_valid", {31'b0, rsp_valid}, 1);
        check_eq("hold_result", rsp_result, got.res);
        check_eq("hold_req_ready", {31'b0, req_ready}, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge Clk);
    @(negedge Clk);
    rsp_ready = 1'b0;
    check_eq("rsp_done", {31'b0, rsp_valid}, 0);
    check_eq("idle_busy", {31'b0, busy}, 0);
    check_eq("we_pulses", we_cnt - base, {31'b0, got.we});
    check_eq("p_we_pulses", p_we_cnt - pbase, {31'b0, got.p_we});
    check_eq("rf_rd", rf[got.rd], exp_rf[got.rd]);
  endtask

  initial begin
    #2;
    check_eq("rst_req_ready", {31'b0, req_ready}, 1);
    check_eq("rst_rf_we", {31'b0, rf_we}, 0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_rsp_result", rsp_result, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    //    op      rs  rt  rd  sh wsrc wen wdata   hold
    do_op(OP_ADD,  0,  0,  1, 0, 1,   1,  1200,   0);
    do_op(OP_ADD,  1,  1,  2, 0, 0,   1,  0,      0);   // 2400
    do_op(OP_ADD,  0,  0,  3, 0, 1,   1,  -2000,  0);
    do_op(OP_ADD,  0,  0,  0, 0, 1,   1,  -2,     0);   // protected copy must not write
    do_op(OP_ADD,  0,  0, 31, 0, 1,   1,  1300,   0);
    do_op(OP_SUB,  3,  0,  5, 0, 0,   1,  0,      0);   // -1998
    do_op(OP_SUB,  3,  3,  7, 0, 0,   1,  0,      0);   // zero flag
    do_op(OP_SRA,  0,  0,  8, 2, 0,   1,  0,      0);   // -1
    do_op(OP_SLL,  0,  0,  9, 2, 0,   1,  0,      0);   // -8
    do_op(OP_GT,   0, 31, 10, 0, 0,   1,  0,      0);   // 0
    do_op(OP_LT,   0, 31, 11, 0, 0,   1,  0,      0);   // 1
    do_op(4'd12,   1,  3,  4, 0, 0,   1,  0,      0);   // illegal: no write
    do_op(OP_ADD,  2,  2,  2, 0, 0,   1,  0,      0);   // reads old R2
    do_op(OP_AND,  1,  3, 13, 0, 0,   0,  0,      0);   // wen=0
    do_op(OP_OR,   1,  3, 12, 0, 0,   1,  0,      5);   // backpressure
    do_op(OP_SRL,  3,  0, 15, 4, 0,   1,  0,      0);

    // Reset asserted while in WB: write must be dropped immediately
    begin
      int base;
      @(negedge Clk);
      req_op = OP_ADD; req_rs = 0; req_rt = 0; req_rd = 6; req_shamt = 0;
      req_wsrc = 1'b1; req_wen = 1'b1; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
      rsp_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      req_valid = 1'b0;
      @(negedge Clk);
      check_eq("wb_we_high", {31'b0, rf_we}, 1);
      base  = we_cnt;
      Rst_n = 1'b0;
      #1;
      check_eq("rst_wb_we", {31'b0, rf_we}, 0);
      check_eq("rst_wb_busy", {31'b0, busy}, 0);
      check_eq("rst_wb_ready", {31'b0, req_ready}, 1);
      @(posedge Clk);
      @(negedge Clk);
      Rst_n     = 1'b1;
      rsp_ready = 1'b0;
      check_eq("rst_wb_nowrite", we_cnt - base, 0);
      check_eq("rst_wb_r6", rf[6], exp_rf[6]);
    end

    do_op(OP_ADD,  1,  2, 14, 0, 0,   1,  0,      0);   // recovery after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
